// File: rtl/weight_update_ram.sv
// rtl/weight_update_ram.sv - row-wide weight memory with saturating in-place update and clear sweep
module weight_update_ram #(
    parameter int NROW     = 16,
    parameter int NCOL     = 16,
    parameter int BITWIDTH = 18,
    localparam int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1,
    localparam int W = NROW * BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [1:0]               cmdOp,
    input  logic [ADDR_BITWIDTH-1:0] cmdAddr,
    input  logic [W-1:0]             cmdData,
    input  logic                     clearReq,
    output logic [W-1:0]             rowOut,
    output logic                     rowOutValid,
    output logic                     satFlag,
    output logic                     busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_UPDATE = 2'b10;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ROW = ADDR_BITWIDTH'(NCOL - 1);

    logic [W-1:0]             mem [NCOL];
    logic [0:0]               state;
    logic [ADDR_BITWIDTH-1:0] clr_ptr;
    logic                     u1_valid;
    logic [ADDR_BITWIDTH-1:0] u1_addr;
    logic [W-1:0]             u1_base;
    logic [W-1:0]             u1_delta;
    logic [W-1:0]             u1_result;
    logic [NROW-1:0]          lane_sat;
    logic                     accept;
    logic                     addr_ok;
    logic                     fwd;
    logic [W-1:0]             rd_row;

    generate
        if (NCOL == (1 << ADDR_BITWIDTH)) begin : g_full_depth
            assign addr_ok = 1'b1;
        end else begin : g_part_depth
            assign addr_ok = {1'b0, cmdAddr} < (ADDR_BITWIDTH + 1)'(NCOL);
        end
    endgenerate

    // Overflow shows as disagreement between the two top bits of the widened sum
    generate
        for (genvar k = 0; k < NROW; k++) begin : g_lane
            logic signed [BITWIDTH:0] sum;
            assign sum = $signed({u1_base[(k+1)*BITWIDTH-1], u1_base[k*BITWIDTH +: BITWIDTH]})
                       + $signed({u1_delta[(k+1)*BITWIDTH-1], u1_delta[k*BITWIDTH +: BITWIDTH]});
            assign lane_sat[k] = sum[BITWIDTH] ^ sum[BITWIDTH-1];
            assign u1_result[k*BITWIDTH +: BITWIDTH] = lane_sat[k]
                ? {sum[BITWIDTH], {(BITWIDTH-1){~sum[BITWIDTH]}}}
                : sum[BITWIDTH-1:0];
        end
    endgenerate

    assign busy     = (state == ST_CLEAR);
    assign cmdReady = (state == ST_IDLE) && !clearReq && !(u1_valid && (cmdOp == OP_WRITE));
    assign accept   = cmdValid && cmdReady;
    assign fwd      = u1_valid && (u1_addr == cmdAddr);
    assign rd_row   = !addr_ok ? '0 : (fwd ? u1_result : mem[cmdAddr]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            u1_valid    <= 1'b0;
            rowOut      <= '0;
            rowOutValid <= 1'b0;
            satFlag     <= 1'b0;
        end else begin
            rowOutValid <= accept && (cmdOp == OP_READ);
            satFlag     <= u1_valid && (|lane_sat);
            u1_valid    <= accept && (cmdOp == OP_UPDATE) && addr_ok;
            if (accept && (cmdOp == OP_READ))
                rowOut <= rd_row;
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == LAST_ROW)
                    state <= ST_IDLE;
            end else if (clearReq && !u1_valid) begin
                // A pending write-back finishes first; the sweep then starts a cycle later
                state   <= ST_CLEAR;
                clr_ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (cmdOp == OP_UPDATE)) begin
            u1_addr  <= cmdAddr;
            u1_base  <= rd_row;
            u1_delta <= cmdData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR)
                mem[clr_ptr] <= '0;
            else if (u1_valid)
                mem[u1_addr] <= u1_result;
            else if (accept && (cmdOp == OP_WRITE) && addr_ok)
                mem[cmdAddr] <= cmdData;
        end
    end

endmodule

// File: tb/tb_weight_update_ram.sv
// tb/tb_weight_update_ram.sv - self-checking bench for weight_update_ram
module tb_weight_update_ram;

    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int AW   = 4;
    localparam int W    = NROW * BW;
    localparam int MAXV = (1 << (BW - 1)) - 1;
    localparam int MINV = -(1 << (BW - 1));

    logic          clk = 1'b0;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic [1:0]    cmdOp;
    logic [AW-1:0] cmdAddr;
    logic [W-1:0]  cmdData;
    logic          clearReq;
    logic [W-1:0]  rowOut;
    logic          rowOutValid;
    logic          satFlag;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int sat_count = 0;

    always #5 clk = ~clk;

    weight_update_ram #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) dut (
        .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdAddr(cmdAddr), .cmdData(cmdData), .clearReq(clearReq),
        .rowOut(rowOut), .rowOutValid(rowOutValid), .satFlag(satFlag), .busy(busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] d;
        for (int k = 0; k < NROW; k++) d[k*BW +: BW] = v[BW-1:0];
        return d;
    endfunction

    function automatic logic [W-1:0] set_lane(input logic [W-1:0] d, input int k, input int v);
        logic [W-1:0] r;
        r = d;
        r[k*BW +: BW] = v[BW-1:0];
        return r;
    endfunction

    function automatic int lane_of(input logic [W-1:0] d, input int k);
        logic signed [BW-1:0] l;
        l = d[k*BW +: BW];
        return int'(l);
    endfunction

    // Model: every accepted command takes effect immediately, in acceptance order
    int           mm [NCOL][NROW];
    int           rem = 0;
    bit           pend_upd = 0, pend_sat = 0, started = 0;
    bit           exp_rv = 0, exp_sat = 0, exp_busy = 0;
    logic [W-1:0] exp_row = '0;

    always @(negedge clk) begin
        bit rdy_exp, acc, upd_now, sat_now;
        int a, s;
        rdy_exp = (rem == 0) && !clearReq && !(pend_upd && cmdOp == 2'b01);
        if (started) begin
            chk("busy", busy, exp_busy);
            chk("rowOutValid", rowOutValid, exp_rv);
            chk("rowOut", rowOut, exp_row);
            chk("satFlag", satFlag, exp_sat);
            chk("cmdReady", cmdReady, rdy_exp);
            if (satFlag === 1'b1) sat_count++;
        end
        if (reset) begin
            rem = NCOL;
            foreach (mm[i, j]) mm[i][j] = 0;
            pend_upd = 0;
            exp_rv = 0;
            exp_sat = 0;
            exp_row = '0;
            started = 1;
        end else begin
            exp_sat = pend_upd && pend_sat;
            exp_rv = 0;
            acc = cmdValid && rdy_exp;
            if (rem > 0) rem--;
            else if (clearReq && !pend_upd) begin
                rem = NCOL;
                foreach (mm[i, j]) mm[i][j] = 0;
            end
            upd_now = 0;
            a = int'(cmdAddr);
            if (acc) begin
                case (cmdOp)
                    2'b00: begin
                        exp_rv = 1;
                        for (int k = 0; k < NROW; k++) begin
                            s = mm[a][k];
                            exp_row[k*BW +: BW] = s[BW-1:0];
                        end
                    end
                    2'b01: for (int k = 0; k < NROW; k++) mm[a][k] = lane_of(cmdData, k);
                    2'b10: begin
                        sat_now = 0;
                        for (int k = 0; k < NROW; k++) begin
                            s = mm[a][k] + lane_of(cmdData, k);
                            if (s > MAXV) begin s = MAXV; sat_now = 1; end
                            if (s < MINV) begin s = MINV; sat_now = 1; end
                            mm[a][k] = s;
                        end
                        upd_now = 1;
                        pend_sat = sat_now;
                    end
                    default: ;
                endcase
            end
            pend_upd = upd_now;
        end
        exp_busy = (rem > 0);
    end

    // All stimulus tasks start and end one time unit after a rising edge
    task automatic do_cmd(input logic [1:0] op, input int addr, input logic [W-1:0] data, output int stalls);
        cmdValid = 1'b1;
        cmdOp = op;
        cmdAddr = addr[AW-1:0];
        cmdData = data;
        stalls = 0;
        while (1) begin
            @(negedge clk);
            if (cmdReady === 1'b1) break;
            stalls++;
            if (stalls > 50) begin
                checks++;
                failures++;
                $display("FAIL cmd_timeout actual=stalled required=accepted op=%0d addr=%0d", op, addr);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    task automatic do_read(input int addr, output logic [W-1:0] row);
        int st;
        do_cmd(2'b00, addr, '0, st);
        @(negedge clk);
        row = rowOut;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string name);
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            if (cmdReady !== 1'b0) rdy_seen = 1;
        end
        chk({name, "_len"}, n, 16);
        chk({name, "_rdy"}, rdy_seen, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] row, d;
        int st, total, s0;
        reset = 1'b1;
        cmdValid = 1'b0;
        cmdOp = 2'b00;
        cmdAddr = '0;
        cmdData = '0;
        clearReq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("rst_sweep");
        for (int r = 0; r < NCOL; r++) begin
            do_read(r, row);
            chk("rst_row_zero", row, '0);
        end

        do_cmd(2'b01, 3, fill(256), st);
        s0 = sat_count;
        do_cmd(2'b10, 3, fill(5), st);
        do_read(3, row);
        chk("upd_row3", row, fill(261));
        chk("upd_row3_nosat", sat_count - s0, 0);

        d = set_lane(set_lane(fill(0), 0, 131000), 1, -131000);
        do_cmd(2'b01, 5, d, st);
        s0 = sat_count;
        d = set_lane(set_lane(fill(0), 0, 100), 1, -100);
        do_cmd(2'b10, 5, d, st);
        do_read(5, row);
        chk("sat_row5", row, set_lane(set_lane(fill(0), 0, 131071), 1, -131072));
        chk("sat_pulses", sat_count - s0, 1);

        do_cmd(2'b01, 7, fill(10), st);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            do_cmd(2'b10, 7, fill(1), st);
            total += st;
        end
        do_read(7, row);
        chk("b2b_row7", row, fill(14));
        chk("b2b_stalls", total, 0);

        do_cmd(2'b10, 2, fill(3), st);
        do_cmd(2'b01, 9, fill(-7), st);
        chk("wr_stall", st, 1);
        do_read(2, row);
        chk("stall_row2", row, fill(3));
        do_read(9, row);
        chk("stall_row9", row, fill(-7));

        do_cmd(2'b11, 9, fill(1), st);
        do_read(9, row);
        chk("reserved_row9", row, fill(-7));

        do_cmd(2'b10, 4, fill(2), st);
        clearReq = 1'b1;
        @(negedge clk);
        chk("clr_defer", busy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("clr_pending", busy, 0);
        @(posedge clk);
        #1;
        clearReq = 1'b0;
        @(negedge clk);
        chk("clr_start", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("restart_sweep");
        for (int r = 0; r < NCOL; r++) begin
            do_read(r, row);
            chk("clr_row_zero", row, '0);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
